// File: rtl/spi_link_pkg.sv
// Shared types and constants for the byte-parallel SPI link.
// The receiver side uses the same package, so header values live here.
package spi_link_pkg;

  localparam int unsigned LINK_W = 8;

  localparam logic [LINK_W-1:0] GRID_HEADER = 8'b11_01_01_01;
  localparam logic [LINK_W-1:0] MOVE_HEADER = 8'b11_10_10_10;

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} tx_state_e;

  typedef enum logic {FRAME_GRID = 1'b0, FRAME_MOVE = 1'b1} frame_type_e;

  // One buffered payload byte plus its framing flags.
  typedef struct packed {
    logic              first;
    frame_type_e       ftype;
    logic              last;
    logic [LINK_W-1:0] data;
  } tx_entry_t;

endpackage

// File: rtl/spi_frame_tx_if.sv
// Payload stream into the frame transmitter (valid/ready, byte-wide).
interface spi_frame_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_type;
  logic                  s_last;

  modport master (output s_valid, s_data, s_type, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_type, s_last, output s_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Next pointers, count and flags from the qualified push/pop.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/spi_frame_tx.sv
// Host-side frame transmitter: buffers payload bytes and sends each packet
// as header + payload under one sel_out window, one byte per clk_out period.
//
// state | meaning
// IDLE  | link quiet, waiting for a frame-start entry at the FIFO head
// SETUP | sel_out raised, header on data_out, clk_out low
// LOW   | clk_out low; stretches while waiting for data, drops overlength bytes
// HIGH  | clk_out high, receiver has sampled the current byte
// HOLD  | one trailing low cycle with sel_out still high
// GAP   | sel_out low for IDLE_GAP cycles before the next frame
module spi_frame_tx
  import spi_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = LINK_W,
  parameter int unsigned BIT_DUR     = 2,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned MAX_PAYLOAD = 250,
  parameter int unsigned IDLE_GAP    = 2,
  parameter logic [DATA_WIDTH-1:0] GRID_HEADER = spi_link_pkg::GRID_HEADER,
  parameter logic [DATA_WIDTH-1:0] MOVE_HEADER = spi_link_pkg::MOVE_HEADER
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_frame_tx_if.slave         s_if,
  output logic                  clk_out,
  output logic                  sel_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_overlen
);

  localparam int unsigned TMAX = (BIT_DUR > IDLE_GAP) ? BIT_DUR : IDLE_GAP;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

  tx_entry_t   wr_entry, head;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  logic        first_pending_q, first_pending_d;
  frame_type_e frame_type_q, frame_type_d;

  tx_state_e             state_q;
  logic [TW-1:0]         timer_q;
  logic [7:0]            pay_cnt_q;
  logic                  last_sent_q;
  logic                  wait_data_q;
  logic                  clk_out_q, sel_out_q, frame_done_q, err_q;
  logic [DATA_WIDTH-1:0] data_out_q;

  // Build the FIFO entry; first/type are latched per frame from s_last history.
  always_comb begin
    fifo_push       = s_if.s_valid && s_if.s_ready;
    first_pending_d = first_pending_q;
    frame_type_d    = frame_type_q;
    wr_entry.first  = first_pending_q;
    wr_entry.ftype  = first_pending_q ? frame_type_e'(s_if.s_type) : frame_type_q;
    wr_entry.last   = s_if.s_last;
    wr_entry.data   = s_if.s_data;
    if (fifo_push) begin
      first_pending_d = s_if.s_last;
      frame_type_d    = wr_entry.ftype;
    end
  end

  // Frame-start tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_pending_q <= 1'b1;
      frame_type_q    <= FRAME_GRID;
    end else begin
      first_pending_q <= first_pending_d;
      frame_type_q    <= frame_type_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(tx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (wr_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pop decision: discard a stray head in IDLE, load the next byte as HIGH
  // ends, or take the byte that ends a stretch / drop phase.
  always_comb begin
    fifo_pop = 1'b0;
    case (state_q)
      IDLE:    fifo_pop = !fifo_empty && !head.first;
      HIGH:    fifo_pop = (timer_q == '0) && !last_sent_q && !fifo_empty &&
                          (pay_cnt_q < 8'(MAX_PAYLOAD));
      LOW:     fifo_pop = wait_data_q && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  // Link FSM with registered link outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      pay_cnt_q    <= '0;
      last_sent_q  <= 1'b0;
      wait_data_q  <= 1'b0;
      clk_out_q    <= 1'b0;
      sel_out_q    <= 1'b0;
      data_out_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (head.first) begin
              state_q    <= SETUP;
              sel_out_q  <= 1'b1;
              clk_out_q  <= 1'b0;
              data_out_q <= (head.ftype == FRAME_MOVE) ? MOVE_HEADER : GRID_HEADER;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q     <= LOW;
          timer_q     <= TW'(BIT_DUR - 1);
          pay_cnt_q   <= '0;
          last_sent_q <= 1'b0;
          wait_data_q <= 1'b0;
        end
        LOW: begin
          if (wait_data_q) begin
            if (!fifo_empty) begin
              if (pay_cnt_q >= 8'(MAX_PAYLOAD)) begin
                err_q <= 1'b1;
                if (head.last) begin
                  state_q     <= HOLD;
                  wait_data_q <= 1'b0;
                end
              end else begin
                data_out_q  <= head.data;
                pay_cnt_q   <= pay_cnt_q + 8'd1;
                last_sent_q <= head.last;
                wait_data_q <= 1'b0;
                timer_q     <= TW'(BIT_DUR - 1);
              end
            end
          end else if (timer_q == '0) begin
            state_q   <= HIGH;
            clk_out_q <= 1'b1;
            timer_q   <= TW'(BIT_DUR - 1);
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        HIGH: begin
          if (timer_q == '0) begin
            clk_out_q <= 1'b0;
            if (last_sent_q) begin
              state_q <= HOLD;
            end else begin
              state_q <= LOW;
              timer_q <= TW'(BIT_DUR - 1);
              if (fifo_pop) begin
                data_out_q  <= head.data;
                pay_cnt_q   <= pay_cnt_q + 8'd1;
                last_sent_q <= head.last;
              end else begin
                wait_data_q <= 1'b1;
              end
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        HOLD: begin
          state_q      <= GAP;
          sel_out_q    <= 1'b0;
          data_out_q   <= '0;
          frame_done_q <= 1'b1;
          timer_q      <= TW'(IDLE_GAP - 1);
        end
        GAP: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else if (!fifo_empty && head.first) begin
            // Start the next frame straight from GAP so frames sit exactly IDLE_GAP apart.
            state_q    <= SETUP;
            sel_out_q  <= 1'b1;
            clk_out_q  <= 1'b0;
            data_out_q <= (head.ftype == FRAME_MOVE) ? MOVE_HEADER : GRID_HEADER;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_if.s_ready = !fifo_full;
  assign clk_out      = clk_out_q;
  assign sel_out      = sel_out_q;
  assign data_out     = data_out_q;
  assign frame_done   = frame_done_q;
  assign err_overlen  = err_q;
  assign busy         = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: a default instance plus one with MAX_PAYLOAD=4.
// Expected link bytes are queued as stimulus is issued; monitors pop them
// on every clk_out rising edge.
module tb_spi_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_frame_tx_if #(.DATA_WIDTH(8)) u_if ();
  spi_frame_tx_if #(.DATA_WIDTH(8)) v_if ();

  logic       clk_out, sel_out, busy, frame_done, err_overlen;
  logic [7:0] data_out;
  logic       o_clk_out, o_sel_out, o_busy, o_frame_done, o_err_overlen;
  logic [7:0] o_data_out;

  spi_frame_tx dut (
    .clk(clk), .rst(rst), .s_if(u_if.slave),
    .clk_out(clk_out), .sel_out(sel_out), .data_out(data_out),
    .busy(busy), .frame_done(frame_done), .err_overlen(err_overlen)
  );

  spi_frame_tx #(.MAX_PAYLOAD(4)) dut_ov (
    .clk(clk), .rst(rst), .s_if(v_if.slave),
    .clk_out(o_clk_out), .sel_out(o_sel_out), .data_out(o_data_out),
    .busy(o_busy), .frame_done(o_frame_done), .err_overlen(o_err_overlen)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_ov[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Main-instance monitor state.
  logic       m_prev_clk = 1'b0, m_prev_sel = 1'b0;
  logic [7:0] m_prev_data = '0;
  int m_sel_len = 0, m_gap_len = 0, m_last_sel = 0, m_last_gap = 0;
  int m_done = 0, m_err = 0, m_rise = 0;
  bit ready_low_seen = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (clk_out === 1'b1 && m_prev_clk === 1'b0) begin
      m_rise++;
      if (exp_q.size() == 0) check("extra_rise", {24'd0, data_out}, 32'hFFFF_FFFF);
      else check("rx_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
    end
    if (clk_out === 1'b1 && m_prev_clk === 1'b1) check("data_stable_high", {24'd0, data_out}, {24'd0, m_prev_data});
    if (rst !== 1'b1 && (frame_done === 1'b1 || (m_prev_sel === 1'b1 && sel_out === 1'b0)))
      check("done_at_sel_fall", {31'd0, frame_done}, {31'd0, (m_prev_sel === 1'b1 && sel_out === 1'b0)});
    if (sel_out === 1'b1) begin
      if (m_prev_sel !== 1'b1) begin m_last_gap = m_gap_len; m_sel_len = 0; end
      m_sel_len++;
    end else begin
      if (m_prev_sel === 1'b1) begin m_last_sel = m_sel_len; m_gap_len = 0; end
      m_gap_len++;
    end
    if (frame_done === 1'b1) m_done++;
    if (err_overlen === 1'b1) m_err++;
    if (u_if.s_ready === 1'b0) ready_low_seen = 1'b1;
    m_prev_clk  = clk_out;
    m_prev_sel  = sel_out;
    m_prev_data = data_out;
  end

  // Overlength-instance monitor state.
  logic o_prev_clk = 1'b0;
  int o_done = 0, o_err = 0;

  always begin
    @(posedge clk);
    #1;
    if (o_clk_out === 1'b1 && o_prev_clk === 1'b0) begin
      if (exp_ov.size() == 0) check("ov_extra_rise", {24'd0, o_data_out}, 32'hFFFF_FFFF);
      else check("ov_rx_byte", {24'd0, o_data_out}, {24'd0, exp_ov.pop_front()});
    end
    if (o_frame_done === 1'b1) o_done++;
    if (o_err_overlen === 1'b1) o_err++;
    o_prev_clk = o_clk_out;
  end

  task automatic push(input bit ov, input logic [7:0] d, input logic t, input logic l);
    int g = 0;
    if (ov) begin
      v_if.s_valid = 1'b1; v_if.s_data = d; v_if.s_type = t; v_if.s_last = l;
      while (v_if.s_ready !== 1'b1 && g < 200) begin @(negedge clk); g++; end
    end else begin
      u_if.s_valid = 1'b1; u_if.s_data = d; u_if.s_type = t; u_if.s_last = l;
      while (u_if.s_ready !== 1'b1 && g < 200) begin @(negedge clk); g++; end
    end
    if (g >= 200) check("push_timeout", 32'(g), 32'd0);
    @(negedge clk);
    u_if.s_valid = 1'b0;
    v_if.s_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit ov);
    int g = 0;
    while ((ov ? o_busy : busy) !== 1'b0 && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) check("idle_timeout", 32'(g), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int d0, e0, r0, g;
    u_if.s_valid = 1'b0; u_if.s_data = '0; u_if.s_type = 1'b0; u_if.s_last = 1'b0;
    v_if.s_valid = 1'b0; v_if.s_data = '0; v_if.s_type = 1'b0; v_if.s_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sel", {31'd0, sel_out}, 32'd0);
    check("rst_clk", {31'd0, clk_out}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_err", {31'd0, err_overlen}, 32'd0);
    check("rst_ready", {31'd0, u_if.s_ready}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Grid frame of three bytes.
    d0 = m_done;
    exp_q.push_back(8'hD5); exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    push(0, 8'h01, 1'b0, 1'b0);
    push(0, 8'h02, 1'b0, 1'b0);
    push(0, 8'h03, 1'b0, 1'b1);
    wait_idle(0);
    check("grid_sel_len", 32'(m_last_sel), 32'd18);
    check("grid_done_cnt", 32'(m_done - d0), 32'd1);
    check("grid_sel_low_after", {31'd0, sel_out}, 32'd0);

    // Move frame then grid frame back-to-back.
    d0 = m_done;
    exp_q.push_back(8'hEA); exp_q.push_back(8'hAA); exp_q.push_back(8'hD5); exp_q.push_back(8'h55);
    push(0, 8'hAA, 1'b1, 1'b1);
    push(0, 8'h55, 1'b0, 1'b1);
    wait_idle(0);
    check("b2b_gap", 32'(m_last_gap), 32'd2);
    check("b2b_sel_len", 32'(m_last_sel), 32'd10);
    check("b2b_done_cnt", 32'(m_done - d0), 32'd2);

    // Underrun: link must stretch with clk_out low.
    r0 = m_rise;
    exp_q.push_back(8'hD5); exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    push(0, 8'h10, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("stretch_rises", 32'(m_rise - r0), 32'd2);
    check("stretch_clk_low", {31'd0, clk_out}, 32'd0);
    check("stretch_sel_high", {31'd0, sel_out}, 32'd1);
    push(0, 8'h11, 1'b0, 1'b1);
    wait_idle(0);
    check("stretch_rises_total", 32'(m_rise - r0), 32'd3);

    // Back-pressure: 20 bytes offered back-to-back.
    ready_low_seen = 1'b0;
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(8'h80 + i));
    for (int i = 0; i < 20; i++) push(0, 8'(8'h80 + i), 1'b0, (i == 19));
    check("bp_ready_dropped", {31'd0, ready_low_seen}, 32'd1);
    wait_idle(0);
    check("bp_all_bytes", 32'(exp_q.size()), 32'd0);

    // Overlength on the MAX_PAYLOAD=4 instance.
    d0 = o_done; e0 = o_err;
    exp_ov.push_back(8'hD5);
    for (int i = 0; i < 4; i++) exp_ov.push_back(8'(8'h31 + i));
    for (int i = 0; i < 6; i++) push(1, 8'(8'h31 + i), 1'b0, (i == 5));
    wait_idle(1);
    check("ov_err_cnt", 32'(o_err - e0), 32'd2);
    check("ov_done_cnt", 32'(o_done - d0), 32'd1);
    check("ov_bytes_left", 32'(exp_ov.size()), 32'd0);

    // Reset in the middle of a frame, just after the header byte.
    r0 = m_rise;
    exp_q.push_back(8'hD5);
    push(0, 8'h21, 1'b0, 1'b0);
    push(0, 8'h22, 1'b0, 1'b0);
    push(0, 8'h23, 1'b0, 1'b1);
    g = 0;
    while (m_rise == r0 && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) check("hdr_timeout", 32'(g), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sel", {31'd0, sel_out}, 32'd0);
    check("mid_rst_clk", {31'd0, clk_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'hD5); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    push(0, 8'h41, 1'b0, 1'b0);
    push(0, 8'h42, 1'b0, 1'b1);
    wait_idle(0);
    check("post_rst_sel_len", 32'(m_last_sel), 32'd14);
    check("post_rst_bytes_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
